// File: rtl/load_use_interlock_if.sv
// Pipeline-to-interlock bundle: ID/EX/MEM hazard inputs and the stall/flush
// controls sent back to the pipeline registers.
interface load_use_interlock_if;
   // ID-stage operand usage
   logic [4:0]  D_Rs;
   logic [4:0]  D_Rt;
   logic        D_UseRs;
   logic        D_UseRt;
   logic        D_MemWr;
   // EX-stage destination
   logic [4:0]  E_Rw;
   logic        E_RegWr;
   logic        E_MemRd;
   // MEM-stage data memory handshake
   logic        M_MemAcc;
   logic        mem_ready;
   // Pipeline controls and status
   logic        stall_F;
   logic        stall_D;
   logic        flush_E;
   logic        freeze;
   logic        mem_err;
   logic [15:0] stall_cnt;

   // Pipeline side: supplies instruction fields, obeys stall/flush/freeze.
   modport master (
      output D_Rs, D_Rt, D_UseRs, D_UseRt, D_MemWr,
      output E_Rw, E_RegWr, E_MemRd,
      output M_MemAcc, mem_ready,
      input  stall_F, stall_D, flush_E, freeze, mem_err, stall_cnt
   );

   // Interlock side: observes hazards, drives the controls.
   modport slave (
      input  D_Rs, D_Rt, D_UseRs, D_UseRt, D_MemWr,
      input  E_Rw, E_RegWr, E_MemRd,
      input  M_MemAcc, mem_ready,
      output stall_F, stall_D, flush_E, freeze, mem_err, stall_cnt
   );
endinterface

// File: rtl/load_use_interlock.sv
// Load-use hazard interlock with data-memory wait freeze, memory timeout
// detection and a saturating stall-cycle counter.
module load_use_interlock (
   input  logic                 clk,
   input  logic                 rst,
   load_use_interlock_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } stateT;

   stateT       state;
   logic [7:0]  waitCnt;
   logic [15:0] stallCnt;
   logic        memErr;

   logic        rsHit;
   logic        rtHit;
   logic        lu;
   logic        pend;
   logic        freezeNow;
   logic        stallNow;
   logic        flushNow;

   // Hazard detection and pipeline control decode; freeze tracks pend with no
   // added latency, and an unreachable encoding behaves like RUN.
   always_comb begin
      // NOTE: every output of this block gets a value up front so no path can infer a latch.
      rsHit     = 1'b0;
      rtHit     = 1'b0;
      lu        = 1'b0;
      pend      = 1'b0;
      freezeNow = 1'b0;
      stallNow  = 1'b0;
      flushNow  = 1'b0;

      rsHit = bus.D_UseRs & (bus.D_Rs == bus.E_Rw);
      // A store's Rt is data only; it is forwarded WB->MEM, so no stall.
      rtHit = bus.D_UseRt & ~bus.D_MemWr & (bus.D_Rt == bus.E_Rw);
      lu    = bus.E_MemRd & bus.E_RegWr & (bus.E_Rw != 5'd0) & (rsHit | rtHit);
      pend  = bus.M_MemAcc & ~bus.mem_ready;

      freezeNow = (state == ERR) ? 1'b1 : pend;
      stallNow  = freezeNow | lu;
      flushNow  = lu & ~freezeNow;
   end

   // Memory-wait state machine with timeout; mem_err is registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state   <= RUN;
         waitCnt <= 8'd0;
         memErr  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               waitCnt <= 8'd0;
               memErr  <= 1'b0;
               if (pend) state <= WAIT;
            end
            WAIT: begin
               if (!pend) begin
                  state   <= RUN;
                  waitCnt <= 8'd0;
               end else if (waitCnt == 8'd255) begin
                  state  <= ERR;
                  memErr <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            ERR: begin
               memErr <= 1'b1;
            end
            default: begin
               state   <= RUN;
               waitCnt <= 8'd0;
               memErr  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt <= 16'd0;
      end else if (stallNow && stallCnt != 16'hFFFF) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   assign bus.stall_F   = stallNow;
   assign bus.stall_D   = stallNow;
   assign bus.flush_E   = flushNow;
   assign bus.freeze    = freezeNow;
   assign bus.mem_err   = memErr;
   assign bus.stall_cnt = stallCnt;

endmodule
